// File: rtl/wb_regfile_pkg.sv
// Shared widths and named constants for the write-back latch and register file.
package wb_regfile_pkg;

  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegNum     = 32;

  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic RstEnable    = 1'b0;

endpackage

// File: rtl/wb_regfile_core.sv
// General register file: one commit write port fed by the WB latch and two
// combinational read ports that bypass the pending WB write.
module wb_regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus,
  parameter int unsigned NREG   = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NREG];
  logic              commit;

  // Register 0 is hard-wired to zero, so writes to it are dropped.
  assign commit = (we == WriteEnable) && (waddr != ADDR_W'(NOPRegAddr));

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= DATA_W'(ZeroWord);
      end
    end else if (commit) begin
      regs[waddr] <= wdata;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic              re,
                                                   input logic [ADDR_W-1:0] raddr);
    if (rst == RstEnable || re == ReadDisable) begin
      return DATA_W'(ZeroWord);
    end else if (raddr == ADDR_W'(NOPRegAddr)) begin
      return DATA_W'(ZeroWord);
    end else if (raddr == waddr && we == WriteEnable) begin
      return wdata;
    end else begin
      return regs[raddr];
    end
  endfunction

  always_comb begin
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: latches the memory-stage destination triple and retires it
// into the register file, with stall/flush control on the latch.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus,
  parameter int unsigned NREG   = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o
);

  logic [ADDR_W-1:0] wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Flush takes priority over stall so a squashed slot never survives a hold.
  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (flush) begin
      wd_d    = ADDR_W'(NOPRegAddr);
      wreg_d  = WriteDisable;
      wdata_d = DATA_W'(ZeroWord);
    end else if (!stall) begin
      wd_d    = wd_i;
      wreg_d  = wreg_i;
      wdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wd_q    <= ADDR_W'(NOPRegAddr);
      wreg_q  <= WriteDisable;
      wdata_q <= DATA_W'(ZeroWord);
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign wb_wd_o    = wd_q;
  assign wb_wreg_o  = wreg_q;
  assign wb_wdata_o = wdata_q;

  wb_regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .we     (wreg_q),
    .waddr  (wd_q),
    .wdata  (wdata_q),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the memory-stage result path.
- Registers the memory stage's destination triple (wd, wreg, wdata) into a WB pipeline latch, then commits it into the 32x32 general register file.
- Provides two combinational read ports for the decode stage, with bypass of the pending WB write.
- Completes the producer/consumer pair with the memory stage: the memory stage drives the triple, this block consumes and retires it.

Parameters:
- DATA_W, 32, register/data width.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers (must equal 2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- stall  in  1  hold WB latch contents.
- flush  in  1  replace incoming triple with NOP.
- wd_i  in  ADDR_W  destination register from memory stage.
- wreg_i  in  1  write request from memory stage.
- wdata_i  in  DATA_W  write data from memory stage.
- re1  in  1  read enable, port 1.
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1.
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2.
- wb_wd_o  out  ADDR_W  WB latch destination (forwarding/debug).
- wb_wreg_o  out  1  WB latch write request.
- wb_wdata_o  out  DATA_W  WB latch data.

Behaviour:
- Reset (rst=0, asynchronous): wb_wd_o=NOPRegAddr (0), wb_wreg_o=WriteDisable, wb_wdata_o=ZeroWord. All NREG registers cleared to 0. rdata1/rdata2 forced to 0 while rst=0.
- WB latch, on rising clk with rst=1:
  - flush=1: load NOP (wd=0, wreg=0, wdata=0). Flush beats stall.
  - else stall=1: hold current contents.
  - else: capture wd_i/wreg_i/wdata_i.
- Commit, on rising clk with rst=1: if wb_wreg_o=1 and wb_wd_o!=0, write regs[wb_wd_o] <= wb_wdata_o.
  - Commit is independent of stall; a held latch rewrites the same value each cycle (idempotent).
  - Register 0 is never written.
- Latency: triple presented at edge N becomes visible on read ports (via bypass) immediately after edge N, and in the array after edge N+1.
- Read port k (combinational), first match wins:
  - rst=0 -> 0.
  - re_k=0 -> 0.
  - raddr_k=0 -> 0.
  - raddr_k==wb_wd_o and wb_wreg_o=1 -> wb_wdata_o (bypass).
  - otherwise regs[raddr_k].
- Both ports may read the same address in the same cycle; each returns the same value.
- wreg=1 with wd=0 passes through the latch unchanged, commits nothing, and is never bypassed.
- Reset mid-operation: the latch entry is lost; partially committed state is irrelevant because all registers clear.
- No width conversion; data is passed bit-exact.

Decomposition:
- Shared defines file: RegAddrBus, RegBus, NOPRegAddr, ZeroWord, WriteEnable/WriteDisable, ReadEnable/ReadDisable, and RstEnable (=1'b0 for this active-low reset).
- One sub-module: regfile_core. It holds the storage array, the commit write port, and the two read ports with bypass, fed by the WB latch outputs.
- The top level holds the WB latch and the stall/flush control.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> wb_* outputs = 0; reading any address 1..31 with re=1 returns 0.
- Write then read: drive wd_i=5, wreg_i=1, wdata_i=32'hDEADBEEF for one cycle -> rdata1 at raddr1=5 = DEADBEEF the cycle after capture (bypass) and stays DEADBEEF after the latch moves on (array).
- Register zero: drive wd_i=0, wreg_i=1, wdata_i=32'h1234 -> wb_wreg_o=1, but raddr1=0 returns 0 and no register changes.
- Stall/flush: hold stall=1 with latch {7,1,AAAA} while wd_i changes to {8,1,BBBB} -> latch holds 7/AAAA, reg 8 stays 0. Assert flush=1 together with stall=1 -> latch becomes NOP; the next wd_i=9 triple is blocked by flush.
- Dual-port collision: raddr1=raddr2=3 with pending WB write of 3 <= 32'h55 -> both rdata = 55. Same setup with re2=0 -> rdata2=0.
- Async reset mid-stream: set regs 1..4 nonzero, pull rst low between clock edges -> all outputs 0 immediately, without a clock edge; after release all registers read 0.
